// File: rtl/fft_pkg.sv
// Shared FFT types and constants: Q1.15 complex sample, fixed-point limits,
// and the elaboration-time rounding helper used to build twiddle tables.
package fft_pkg;

    typedef struct packed {
        logic signed [15:0] re;
        logic signed [15:0] im;
    } cplx_t;

    typedef enum logic {
        FILL = 1'b0,
        PAIR = 1'b1
    } state_t;

    localparam int  Q_ONE_MAX = 32767;
    localparam int  Q_NEG_ONE = -32768;
    localparam real PI        = 3.14159265358979323846;

    // Scale to 2^(width-1), round half away from zero, clip to the signed range.
    function automatic longint q_round(input real x, input int width);
        real    s;
        real    r;
        longint v;
        longint hi;
        longint lo;
        s = x * real'(longint'(1) << (width - 1));
        if (s >= 0.0) r = $floor(s + 0.5);
        else          r = -$floor(-s + 0.5);
        v = longint'(r);
        if (width == 16) begin
            hi = longint'(Q_ONE_MAX);
            lo = longint'(Q_NEG_ONE);
        end else begin
            hi = (longint'(1) << (width - 1)) - 1;
            lo = -(longint'(1) << (width - 1));
        end
        if (v > hi) v = hi;
        if (v < lo) v = lo;
        return v;
    endfunction

endpackage

// File: rtl/twiddle_rom.sv
// Combinational twiddle lookup W_N^idx for idx in [0, N/2); the table is
// built entirely at elaboration so no arithmetic exists at runtime.
module twiddle_rom
    import fft_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int N     = 16
) (
    input  logic [$clog2(N)-2:0]     idx,
    output logic signed [WIDTH-1:0]  w_re,
    output logic signed [WIDTH-1:0]  w_im
);

    localparam int HALF = N / 2;

    logic signed [WIDTH-1:0] tbl_re [HALF];
    logic signed [WIDTH-1:0] tbl_im [HALF];

    for (genvar k = 0; k < HALF; k++) begin : g_tbl
        localparam real    ANG = 2.0 * PI * real'(k) / real'(N);
        localparam longint RE  = q_round($cos(ANG), WIDTH);
        localparam longint IM  = q_round(-$sin(ANG), WIDTH);
        assign tbl_re[k] = RE[WIDTH-1:0];
        assign tbl_im[k] = IM[WIDTH-1:0];
    end

    assign w_re = tbl_re[idx];
    assign w_im = tbl_im[idx];

endmodule

// File: rtl/bf_pair_feeder.sv
// Radix-2 DIF stage front end: buffers the first half of each frame, then
// pairs sample k with sample k+N/2 and presents the pair with twiddle W_N^k.
//
//  state | meaning
//  FILL  | cnt MSB = 0: store incoming sample k into the half-frame buffer
//  PAIR  | cnt MSB = 1: incoming sample is b; load (buf[k], b, W^k) to output
module bf_pair_feeder
    import fft_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int N     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [WIDTH-1:0]  in_re,
    input  logic signed [WIDTH-1:0]  in_im,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [WIDTH-1:0]  a_re,
    output logic signed [WIDTH-1:0]  a_im,
    output logic signed [WIDTH-1:0]  b_re,
    output logic signed [WIDTH-1:0]  b_im,
    output logic signed [WIDTH-1:0]  w_re,
    output logic signed [WIDTH-1:0]  w_im,
    output logic [$clog2(N)-2:0]     out_idx,
    output logic                     out_last
);

    localparam int                LOGN   = $clog2(N);
    localparam int                HALF   = N / 2;
    localparam logic [LOGN-2:0]   K_LAST = (LOGN-1)'(HALF - 1);

    logic [LOGN-1:0]         cnt;
    logic [LOGN-2:0]         k;
    state_t                  state;
    logic                    accept;
    logic                    load;
    logic                    buf_wr;
    logic signed [WIDTH-1:0] buf_re [HALF];
    logic signed [WIDTH-1:0] buf_im [HALF];
    logic signed [WIDTH-1:0] rom_re;
    logic signed [WIDTH-1:0] rom_im;

    assign k = cnt[LOGN-2:0];

    // The sample counter is the state register; its MSB is the FSM state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= cnt + LOGN'(1);
        end
    end

    always_comb begin
        state    = state_t'(cnt[LOGN-1]);
        in_ready = 1'b1;
        load     = 1'b0;
        buf_wr   = 1'b0;
        case (state)
            FILL: begin
                in_ready = 1'b1;
                buf_wr   = in_valid;
            end
            PAIR: begin
                in_ready = !out_valid || out_ready;
                load     = in_valid && (!out_valid || out_ready);
            end
            default: ;
        endcase
        accept = in_valid && in_ready;
    end

    always_ff @(posedge clk) begin
        if (buf_wr) begin
            buf_re[k] <= in_re;
            buf_im[k] <= in_im;
        end
    end

    twiddle_rom #(
        .WIDTH (WIDTH),
        .N     (N)
    ) u_rom (
        .idx  (k),
        .w_re (rom_re),
        .w_im (rom_im)
    );

    // A consume and a new load in the same cycle keep out_valid asserted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            a_re      <= '0;
            a_im      <= '0;
            b_re      <= '0;
            b_im      <= '0;
            w_re      <= '0;
            w_im      <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            a_re      <= buf_re[k];
            a_im      <= buf_im[k];
            b_re      <= in_re;
            b_im      <= in_im;
            w_re      <= rom_re;
            w_im      <= rom_im;
            out_idx   <= k;
            out_last  <= (k == K_LAST);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bf_pair_feeder.sv
// Scoreboard bench for bf_pair_feeder at N = 8, 16 and 64: drivers push the
// expected pair on each b beat, per-instance monitors pop on every handshake.
module tb_bf_pair_feeder;

    typedef struct {
        int k;
        int are;
        int aim;
        int bre;
        int bim;
        int wre;
        int wim;
        bit last;
        int due;
    } item_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // N = 8 instance
    logic               iv8, ir8, ov8, or8, last8;
    logic signed [15:0] ire8, iim8, are8, aim8, bre8, bim8, wre8, wim8;
    logic [1:0]         idx8;
    // N = 16 instance
    logic               iv16, ir16, ov16, or16, last16;
    logic signed [15:0] ire16, iim16, are16, aim16, bre16, bim16, wre16, wim16;
    logic [2:0]         idx16;
    // N = 64 instance
    logic               iv64, ir64, ov64, or64, last64;
    logic signed [15:0] ire64, iim64, are64, aim64, bre64, bim64, wre64, wim64;
    logic [4:0]         idx64;

    bf_pair_feeder #(.WIDTH(16), .N(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .in_re(ire8), .in_im(iim8),
        .out_valid(ov8), .out_ready(or8), .a_re(are8), .a_im(aim8), .b_re(bre8), .b_im(bim8),
        .w_re(wre8), .w_im(wim8), .out_idx(idx8), .out_last(last8));

    bf_pair_feeder #(.WIDTH(16), .N(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .in_re(ire16), .in_im(iim16),
        .out_valid(ov16), .out_ready(or16), .a_re(are16), .a_im(aim16), .b_re(bre16), .b_im(bim16),
        .w_re(wre16), .w_im(wim16), .out_idx(idx16), .out_last(last16));

    bf_pair_feeder #(.WIDTH(16), .N(64)) dut64 (
        .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(ir64), .in_re(ire64), .in_im(iim64),
        .out_valid(ov64), .out_ready(or64), .a_re(are64), .a_im(aim64), .b_re(bre64), .b_im(bim64),
        .w_re(wre64), .w_im(wim64), .out_idx(idx64), .out_last(last64));

    item_t q8[$];
    item_t q16[$];
    item_t q64[$];

    int mre [3][32];
    int mim [3][32];
    int mc  [3];

    // Hand-computed W_8^k.
    int tw8re [4] = '{32767, 23170, 0, -23170};
    int tw8im [4] = '{0, -23170, -32768, -23170};

    function automatic int twm(input int k, input int n, input bit im_part);
        real ang;
        real x;
        real s;
        real r;
        int  v;
        ang = 2.0 * 3.14159265358979323846 * real'(k) / real'(n);
        x   = im_part ? -$sin(ang) : $cos(ang);
        s   = x * 32768.0;
        if (s >= 0.0) r = $floor(s + 0.5);
        else          r = -$floor(-s + 0.5);
        v = int'(r);
        if (v > 32767)  v = 32767;
        if (v < -32768) v = -32768;
        return v;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_item(input string nm, input item_t e, input item_t a);
        total++;
        if (e.k != a.k || e.are != a.are || e.aim != a.aim || e.bre != a.bre ||
            e.bim != a.bim || e.wre != a.wre || e.wim != a.wim || e.last != a.last ||
            (e.due >= 0 && e.due != a.due)) begin
            bad++;
            $display("FAIL %s: got k=%0d a=(%0d,%0d) b=(%0d,%0d) w=(%0d,%0d) last=%0d cyc=%0d expected k=%0d a=(%0d,%0d) b=(%0d,%0d) w=(%0d,%0d) last=%0d cyc=%0d",
                     nm, a.k, a.are, a.aim, a.bre, a.bim, a.wre, a.wim, a.last, a.due,
                     e.k, e.are, e.aim, e.bre, e.bim, e.wre, e.wim, e.last, e.due);
        end
    endtask

    task automatic unexpected(input string nm, input int k);
        total++;
        bad++;
        $display("FAIL %s: got unexpected pair k=%0d expected no output", nm, k);
    endtask

    // Reference model: store first half, emit (k, buf[k], b, W^k) on second half.
    task automatic model_accept(input int d, input int n, input int re, input int im, input int due);
        int    h;
        int    kk;
        item_t it;
        h = n / 2;
        if (mc[d] < h) begin
            mre[d][mc[d]] = re;
            mim[d][mc[d]] = im;
        end else begin
            kk      = mc[d] - h;
            it.k    = kk;
            it.are  = mre[d][kk];
            it.aim  = mim[d][kk];
            it.bre  = re;
            it.bim  = im;
            if (d == 0) begin
                it.wre = tw8re[kk];
                it.wim = tw8im[kk];
            end else begin
                it.wre = twm(kk, n, 1'b0);
                it.wim = twm(kk, n, 1'b1);
            end
            it.last = (kk == h - 1);
            it.due  = due;
            case (d)
                0:       q8.push_back(it);
                1:       q16.push_back(it);
                default: q64.push_back(it);
            endcase
        end
        mc[d] = (mc[d] + 1) % n;
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat is accepted.
    task automatic send8(input int re, input int im, input bit want_due, input bit ready_must);
        bit got;
        int tries;
        got   = 1'b0;
        tries = 0;
        iv8   = 1'b1;
        ire8  = 16'(re);
        iim8  = 16'(im);
        while (!got && tries < 50) begin
            @(negedge clk);
            got = ir8;
            if (ready_must && tries == 0) chk("b2b_in_ready", longint'(ir8), 1);
            @(posedge clk);
            #1;
            tries++;
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL send8_timeout: got no acceptance expected accept within 50 cycles");
        end else begin
            model_accept(0, 8, re, im, want_due ? cyc : -1);
        end
    endtask

    task automatic ramp8(input bit want_due);
        for (int n = 0; n < 8; n++) send8(1000 * n, 0, want_due, 1'b0);
        iv8 = 1'b0;
    endtask

    task automatic drain_check(input string nm, input int left);
        chk(nm, longint'(left), 0);
    endtask

    always @(negedge clk) begin
        item_t e;
        item_t a;
        if (!rst && ov8 && or8) begin
            if (q8.size() == 0) unexpected("pair8", int'(idx8));
            else begin
                e = q8.pop_front();
                a = '{int'(idx8), int'(are8), int'(aim8), int'(bre8), int'(bim8),
                      int'(wre8), int'(wim8), last8, cyc};
                chk_item("pair8", e, a);
            end
        end
    end

    always @(negedge clk) begin
        item_t e;
        item_t a;
        if (!rst && ov16 && or16) begin
            if (q16.size() == 0) unexpected("pair16", int'(idx16));
            else begin
                e = q16.pop_front();
                a = '{int'(idx16), int'(are16), int'(aim16), int'(bre16), int'(bim16),
                      int'(wre16), int'(wim16), last16, cyc};
                chk_item("pair16", e, a);
            end
        end
    end

    always @(negedge clk) begin
        item_t e;
        item_t a;
        if (!rst && ov64 && or64) begin
            if (q64.size() == 0) unexpected("pair64", int'(idx64));
            else begin
                e = q64.pop_front();
                a = '{int'(idx64), int'(are64), int'(aim64), int'(bre64), int'(bim64),
                      int'(wre64), int'(wim64), last64, cyc};
                chk_item("tw64", e, a);
                if (idx64 == 5'd16) begin
                    chk("tw64_k16_re", longint'(wre64), 0);
                    chk("tw64_k16_im", longint'(wim64), -32768);
                end
            end
        end
    end

    bit run16 = 1'b0;

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int  sent;
        int  iter;
        int  re;
        int  im;
        bit  acc;
        bit  pend;

        rst = 1'b1;
        iv8 = 1'b0;  ire8 = '0;  iim8 = '0;  or8 = 1'b1;
        iv16 = 1'b0; ire16 = '0; iim16 = '0; or16 = 1'b1;
        iv64 = 1'b0; ire64 = '0; iim64 = '0; or64 = 1'b1;
        for (int d = 0; d < 3; d++) mc[d] = 0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", longint'(ov8), 0);
        chk("rst_out_last", longint'(last8), 0);
        chk("rst_out_idx", longint'(idx8), 0);
        chk("rst_a_re", longint'(are8), 0);
        chk("rst_b_im", longint'(bim8), 0);
        chk("rst_w_re", longint'(wre8), 0);
        chk("rst_in_ready", longint'(ir8), 1);
        @(posedge clk);
        #1;

        // Basic ramp with latency checks.
        ramp8(1'b1);
        repeat (3) @(posedge clk);
        #1 drain_check("s1_drain", q8.size());

        // Two back-to-back frames, in_valid held high.
        for (int n = 0; n < 16; n++)
            send8((n < 8) ? (-3000 + 111 * n) : (32767 - 5 * n), 37 * n - 200, 1'b1, 1'b1);
        iv8 = 1'b0;
        repeat (3) @(posedge clk);
        #1 drain_check("s2_drain", q8.size());

        // Backpressure after the k = 1 pair.
        for (int n = 0; n < 6; n++) send8(1000 * n, -n, 1'b0, 1'b0);
        or8  = 1'b0;
        ire8 = 16'sd6000;
        iim8 = -16'sd6;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_in_ready", longint'(ir8), 0);
            chk("bp_out_valid", longint'(ov8), 1);
            chk("bp_idx", longint'(idx8), 1);
            chk("bp_a_re", longint'(are8), 1000);
            chk("bp_b_re", longint'(bre8), 5000);
            chk("bp_b_im", longint'(bim8), -5);
            @(posedge clk);
            #1;
        end
        or8 = 1'b1;
        send8(6000, -6, 1'b0, 1'b0);
        send8(7000, -7, 1'b0, 1'b0);
        iv8 = 1'b0;
        repeat (3) @(posedge clk);
        #1 drain_check("s3_drain", q8.size());

        // Reset after sample 5, then a fresh ramp.
        for (int n = 0; n < 6; n++) send8(1000 * n + 50, 0, 1'b0, 1'b0);
        iv8 = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        mc[0] = 0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_mid_out_valid", longint'(ov8), 0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        drain_check("s4_pre_drain", q8.size());
        ramp8(1'b1);
        repeat (3) @(posedge clk);
        #1 drain_check("s4_drain", q8.size());

        // Random handshakes at N = 16, 50 frames.
        run16 = 1'b1;
        fork
            begin
                while (run16) begin
                    @(posedge clk);
                    #1 or16 = run16 ? ($urandom_range(0, 2) != 0) : 1'b1;
                end
            end
        join_none
        sent = 0;
        iter = 0;
        pend = 1'b0;
        re   = 0;
        im   = 0;
        while (sent < 800 && iter < 20000) begin
            if (!pend) begin
                case ($urandom_range(0, 3))
                    0:       re = -32768;
                    1:       re = 32767;
                    default: re = int'($urandom_range(0, 65535)) - 32768;
                endcase
                case ($urandom_range(0, 3))
                    0:       im = 32767;
                    1:       im = -32768;
                    default: im = int'($urandom_range(0, 65535)) - 32768;
                endcase
                pend = 1'b1;
            end
            iv16  = ($urandom_range(0, 3) != 0);
            ire16 = 16'(re);
            iim16 = 16'(im);
            @(negedge clk);
            acc = iv16 && ir16;
            @(posedge clk);
            #1;
            if (acc) begin
                model_accept(1, 16, re, im, -1);
                sent++;
                pend = 1'b0;
            end
            iter++;
        end
        iv16 = 1'b0;
        chk("rand16_samples_sent", longint'(sent), 800);
        run16 = 1'b0;
        repeat (6) @(posedge clk);
        #1 drain_check("rand16_drain", q16.size());

        // Twiddle sweep at N = 64.
        for (int n = 0; n < 64; n++) begin
            iv64  = 1'b1;
            ire64 = 16'(511 * n - 16000);
            iim64 = 16'(20000 - 300 * n);
            @(negedge clk);
            acc = ir64;
            @(posedge clk);
            #1;
            if (acc) model_accept(2, 64, 511 * n - 16000, 20000 - 300 * n, cyc);
            else chk("tw64_in_ready", longint'(acc), 1);
        end
        iv64 = 1'b0;
        repeat (3) @(posedge clk);
        #1 drain_check("tw64_drain", q64.size());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
